// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage RV32I pipeline.
// It resolves memory-port waits, branch/jump redirects and load-use hazards
// in fixed priority order. It also keeps saturating performance counters
// and a sticky memory-wait watchdog. The stall/flush controls are
// combinational. State, counters and the watchdog are registered.
module hazard_ctrl #(
   parameter int CNT_W        = 32,
   parameter int WAIT_TIMEOUT = 1024
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_redirect,
   input  logic             imem_wait,
   input  logic             dmem_wait,
   output logic             pc_stall,
   output logic             if_id_stall,
   output logic             if_id_flush,
   output logic             id_ex_stall,
   output logic             id_ex_flush,
   output logic             ex_mem_stall,
   output logic             mem_wb_stall,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             timeout_err
);

   localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(WAIT_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      MEMWAIT    = 2'd1,
      REDIR_PEND = 2'd2
   } state_t;

   state_t            state_r;
   logic [WAIT_W-1:0] wait_cnt_r;
   logic              mw_s;
   logic              lu_s;
   logic              redir_s;

   // Hazard detection: x0 never matches, and a double rs1/rs2 match is still one bubble.
   always_comb begin
      mw_s    = imem_wait | dmem_wait;
      lu_s    = ex_is_load & (ex_rd != 5'd0) &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
      // A redirect held back during a wait is applied on the cycle the wait drops.
      redir_s = ~mw_s & (ex_redirect | (state_r == REDIR_PEND));
   end

   // Priority decode of the pipeline controls: memory wait, redirect, load-use.
   always_comb begin
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_stall  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_stall = 1'b0;
      mem_wb_stall = 1'b0;
      if (mw_s) begin
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_stall  = 1'b1;
         ex_mem_stall = 1'b1;
         mem_wb_stall = 1'b1;
      end else if (redir_s) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
      end else if (lu_s) begin
         pc_stall     = 1'b1;
         if_id_stall  = 1'b1;
         id_ex_flush  = 1'b1;
      end else begin
         pc_stall     = 1'b0;
      end
   end

   // Wait/redirect FSM: remembers a redirect that arrives while memory is stalling.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state_r <= RUN;
      end else begin
         case (state_r)
            RUN, MEMWAIT: begin
               if (mw_s && ex_redirect) begin
                  state_r <= REDIR_PEND;
               end else if (mw_s) begin
                  state_r <= MEMWAIT;
               end else begin
                  state_r <= RUN;
               end
            end
            REDIR_PEND: begin
               if (mw_s) begin
                  state_r <= REDIR_PEND;
               end else begin
                  state_r <= RUN;
               end
            end
            default: state_r <= RUN;
         endcase
      end
   end

   // Saturating counters of stalled cycles and applied redirect flushes.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         stall_cnt <= {CNT_W{1'b0}};
         flush_cnt <= {CNT_W{1'b0}};
      end else begin
         if (pc_stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
         end else begin
            stall_cnt <= stall_cnt;
         end
         if (if_id_flush && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_ONE;
         end else begin
            flush_cnt <= flush_cnt;
         end
      end
   end

   // Watchdog: counts consecutive wait cycles and latches a sticky timeout flag.
   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         wait_cnt_r  <= {WAIT_W{1'b0}};
         timeout_err <= 1'b0;
      end else if (mw_s) begin
         if (wait_cnt_r != WAIT_MAX) begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
         if (wait_cnt_r >= WAIT_LAST) begin
            timeout_err <= 1'b1;
         end else begin
            timeout_err <= timeout_err;
         end
      end else begin
         wait_cnt_r  <= {WAIT_W{1'b0}};
         timeout_err <= timeout_err;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic for hazard_ctrl.
// Every cycle is compared against a behavioural model built from the priority rules.
module tb_hazard_ctrl;

   localparam int CNT_W   = 4;
   localparam int TO      = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic ACLK = 1'b0;
   logic ARESETn;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, imem_wait, dmem_wait;
   logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
   logic ex_mem_stall, mem_wb_stall, timeout_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;

   // reference model state
   int stall_m, flush_m, wait_m;
   bit timeout_m, pend_m;

   hazard_ctrl #(.CNT_W(CNT_W), .WAIT_TIMEOUT(TO)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
      .imem_wait(imem_wait), .dmem_wait(dmem_wait),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
      .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
      .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .timeout_err(timeout_err)
   );

   always #5 ACLK = ~ACLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rd = 5'd0; ex_is_load = 1'b0; ex_redirect = 1'b0;
      imem_wait = 1'b0; dmem_wait = 1'b0;
   endtask

   // One clock: check at the falling edge, advance the model, return #1 after the rising edge.
   task automatic cycle();
      bit mw, lu, redir;
      bit e_pc, e_ifs, e_iff, e_ids, e_idf, e_exs, e_wbs;
      @(negedge ACLK);
      mw    = imem_wait | dmem_wait;
      lu    = ex_is_load && ex_rd != 5'd0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      redir = !mw && (ex_redirect || pend_m);
      e_pc = mw || (!redir && lu);
      e_ifs = e_pc;
      e_iff = redir;
      e_ids = mw;
      e_idf = !mw && (redir || lu);
      e_exs = mw;
      e_wbs = mw;
      if (checking) begin
         check_val("ctrl",
                   {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_stall},
                   {e_pc, e_ifs, e_iff, e_ids, e_idf, e_exs, e_wbs});
         check_val("stall_cnt", stall_cnt, stall_m);
         check_val("flush_cnt", flush_cnt, flush_m);
         check_val("timeout_err", timeout_err, timeout_m);
      end
      if (!ARESETn) begin
         stall_m = 0; flush_m = 0; wait_m = 0; timeout_m = 1'b0; pend_m = 1'b0;
      end else begin
         if (e_pc && stall_m < CNT_MAX) stall_m++;
         if (redir && flush_m < CNT_MAX) flush_m++;
         if (mw) begin
            if (wait_m < TO) wait_m++;
            if (wait_m == TO) timeout_m = 1'b1;
         end else begin
            wait_m = 0;
         end
         if (mw && ex_redirect) pend_m = 1'b1;
         else if (!mw) pend_m = 1'b0;
      end
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_reset(input int n);
      ARESETn = 1'b0;
      clear_inputs();
      for (int i = 0; i < n; i++) cycle();
      ARESETn = 1'b1;
   endtask

   task automatic set_load_use(input logic [4:0] rd);
      ex_is_load = 1'b1; ex_rd = rd; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
   endtask

   initial begin
      int burst;
      ARESETn = 1'b0;
      clear_inputs();
      stall_m = 0; flush_m = 0; wait_m = 0; timeout_m = 1'b0; pend_m = 1'b0;
      @(posedge ACLK); #1;
      do_reset(3);
      checking = 1'b1;

      // Idle after reset
      cycle();
      check_val("rst_stall_cnt", stall_cnt, 0);
      check_val("rst_pc_stall", pc_stall, 0);

      // Load-use on rs2, then the same with rd = x0
      set_load_use(5'd5);
      #1;
      check_val("lu_pc_stall", pc_stall, 1);
      check_val("lu_id_ex_flush", id_ex_flush, 1);
      cycle();
      clear_inputs();
      check_val("lu_stall_cnt", stall_cnt, 1);
      set_load_use(5'd0);
      id_rs2 = 5'd0;
      #1;
      check_val("x0_pc_stall", pc_stall, 0);
      cycle();
      clear_inputs();

      // Redirect overrides load-use
      do_reset(1);
      set_load_use(5'd5);
      ex_redirect = 1'b1;
      #1;
      check_val("redir_pc_stall", pc_stall, 0);
      check_val("redir_flushes", {if_id_flush, id_ex_flush}, 2'b11);
      cycle();
      clear_inputs();
      check_val("redir_flush_cnt", flush_cnt, 1);

      // Redirect arriving during a data wait is deferred and applied once
      do_reset(1);
      dmem_wait = 1'b1; ex_redirect = 1'b1;
      cycle();
      ex_redirect = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_val("pend_no_flush", if_id_flush, 0);
         cycle();
      end
      dmem_wait = 1'b0;
      #1;
      check_val("pend_flushes", {if_id_flush, id_ex_flush, pc_stall}, 3'b110);
      cycle();
      #1;
      check_val("pend_once", if_id_flush, 0);
      check_val("pend_flush_cnt", flush_cnt, 1);
      check_val("pend_stall_cnt", stall_cnt, 4);
      cycle();

      // Watchdog
      do_reset(1);
      imem_wait = 1'b1;
      for (int i = 0; i < 7; i++) cycle();
      check_val("wd_before", timeout_err, 0);
      cycle();
      check_val("wd_set", timeout_err, 1);
      cycle(); cycle();
      imem_wait = 1'b0;
      cycle(); cycle();
      check_val("wd_sticky", timeout_err, 1);
      do_reset(1);
      check_val("wd_cleared", timeout_err, 0);

      // Counter saturation
      set_load_use(5'd5);
      for (int i = 0; i < 20; i++) cycle();
      check_val("sat_stall_cnt", stall_cnt, 15);
      clear_inputs();
      cycle();

      // Randomized traffic
      burst = 0;
      for (int n = 0; n < 3000; n++) begin
         ARESETn     = ($urandom_range(0, 299) != 0);
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         ex_rd       = 5'($urandom_range(0, 3));
         id_use_rs1  = 1'($urandom_range(0, 1));
         id_use_rs2  = 1'($urandom_range(0, 1));
         ex_is_load  = 1'($urandom_range(0, 1));
         ex_redirect = ($urandom_range(0, 3) == 0);
         if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(4, 12);
         imem_wait   = ($urandom_range(0, 7) == 0);
         dmem_wait   = ($urandom_range(0, 7) == 0) || (burst != 0);
         if (burst != 0) burst--;
         cycle();
      end
      ARESETn = 1'b1;
      clear_inputs();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
